// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and redirect decode for the instruction prefetch unit.
// Holds the default reset PC, instruction width and fetch increment.
package ifu_prefetch_pkg;

    localparam int unsigned IFU_INST_W   = 32;
    localparam int unsigned IFU_PC_INC   = 4;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RedirNone,
        RedirJump,
        RedirReset
    } redir_e;

    // A debug reset outranks a normal jump when both arrive together.
    function automatic redir_e redir_sel(input logic jtag_reset, input logic jump_en);
        if (jtag_reset) begin
            return RedirReset;
        end
        if (jump_en) begin
            return RedirJump;
        end
        return RedirNone;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: DEPTH entries of W bits, occupancy count, synchronous flush.
// Flush wins over push and pop in the same cycle.
module ifu_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 wdata_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    assign rdata_o = mem[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: one outstanding ROM fetch feeding a small buffer to decode.
// Define IFU_BYPASS_EN to forward a fresh ROM word straight to decode when the buffer is empty.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = IFU_INST_W,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          jtag_halt_i,
    input  logic          jtag_reset_i,
    output logic          rom_req_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic          rom_gnt_i,
    input  logic          rom_rvalid_i,
    input  logic [DW-1:0] rom_rdata_i,
    output logic          inst_valid_o,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_addr_o,
    input  logic          inst_ready_i
);

    localparam int unsigned    CW      = $clog2(DEPTH + 1);
    localparam int unsigned    EW      = DW + AW;
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

    logic [AW-1:0] pc_q, pc_d, issue_addr_q;
    logic          inflight_q, inflight_d, stale_q, stale_d;
    logic          flush, gnt_fire, accept, push, pop, bypass;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_rdata;
    logic [CW:0]   occupancy;
    redir_e        redir;

    assign redir     = redir_sel(jtag_reset_i, jump_en_i);
    assign flush     = (redir != RedirNone);
    // Reserve a slot for the outstanding response so the buffer can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign rom_req_o = rstn && !jtag_halt_i && !flush && (occupancy < DEPTH_C);
    assign rom_addr_o = pc_q;
    assign gnt_fire  = rom_req_o && rom_gnt_i;
    // A response with no recorded request (e.g. straight after reset) is ignored.
    assign accept    = rom_rvalid_i && inflight_q && !stale_q;

`ifdef IFU_BYPASS_EN
    assign bypass = fifo_empty && accept;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid_o = (!fifo_empty || bypass) && !jtag_halt_i;
    assign pop          = inst_valid_o && inst_ready_i && !bypass;
    assign push         = accept && !(bypass && inst_valid_o && inst_ready_i);

    always_comb begin
        inst_o      = '0;
        inst_addr_o = '0;
        if (bypass) begin
            inst_o      = rom_rdata_i;
            inst_addr_o = issue_addr_q;
        end else if (!fifo_empty) begin
            {inst_o, inst_addr_o} = fifo_rdata;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (redir)
            RedirReset: pc_d = RESET_PC;
            RedirJump:  pc_d = jump_addr_i;
            default: begin
                if (gnt_fire) begin
                    pc_d = pc_q + AW'(IFU_PC_INC);
                end
            end
        endcase
        inflight_d = gnt_fire || (inflight_q && !rom_rvalid_i);
        // Anything still outstanding past a redirect is discarded when it lands.
        if (flush) begin
            stale_d = inflight_q && !rom_rvalid_i;
        end else begin
            stale_d = stale_q && !rom_rvalid_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            issue_addr_q <= '0;
            inflight_q   <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            if (gnt_fire) begin
                issue_addr_q <= pc_q;
            end
        end
    end

    ifu_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({rom_rdata_i, issue_addr_q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: ROM returns ~addr one cycle after each grant.
// Build with IFU_BYPASS_EN defined to exercise the bypass path.
module tb_ifu_prefetch;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          jump_en_i, jtag_halt_i, jtag_reset_i;
    logic [AW-1:0] jump_addr_i;
    logic          rom_req_o, rom_gnt_i, rom_rvalid_i;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_rdata_i;
    logic          inst_valid_o, inst_ready_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gcount = 0;
    int          first_grant = -1;
    int          first_valid = -1;
    logic [31:0] exp_q[$];
    logic [31:0] gq[$];
    logic [31:0] pend_addr = '0;
    bit          pend = 1'b0;
    bit          force_rv = 1'b0;
    logic [31:0] e;

    ifu_prefetch #(
        .AW       (AW),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .jtag_halt_i  (jtag_halt_i),
        .jtag_reset_i (jtag_reset_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_run(input logic [31:0] base, input int num);
        for (int i = 0; i < num; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // ROM model: response exactly one cycle after the grant.
    always @(posedge clk) begin
        #2;
        rom_rvalid_i = pend || force_rv;
        rom_rdata_i  = force_rv ? 32'hBAD0_BAD0 : ~pend_addr;
    end

    // Grant logger and scoreboard monitor.
    always @(negedge clk) begin
        pend      = rstn && rom_req_o && rom_gnt_i;
        pend_addr = rom_addr_o;
        if (pend) begin
            gq.push_back(rom_addr_o);
            gcount++;
            if (first_grant < 0) first_grant = cyc;
        end
        if (inst_valid_o && first_valid < 0) first_valid = cyc;
        if (inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got addr %h expected no issue", inst_addr_o);
            end else begin
                e = exp_q.pop_front();
                check("issue_addr", inst_addr_o, e);
                check("issue_data", inst_o, ~e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hg, hv;
        bit  seen;
        rstn = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; jtag_halt_i = 1'b0;
        jtag_reset_i = 1'b0; rom_gnt_i = 1'b1; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
        inst_ready_i = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", 32'(rom_req_o), 32'd0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_inst_addr", inst_addr_o, 32'd0);

        // Release with a spurious response in the first cycle: it must be ignored.
        tick();
        expect_run(32'h0, 6);
        gq.delete();
        rstn = 1'b1;
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        tick();
        tick();
        check("grant_cnt3", 32'(gq.size() >= 3), 32'd1);
        if (gq.size() >= 3) begin
            check("grant0", gq[0], 32'h0);
            check("grant1", gq[1], 32'h4);
            check("grant2", gq[2], 32'h8);
        end
        drain(40);
        check("first_latency", 32'(first_valid - first_grant), 32'(LAT));
        inst_ready_i = 1'b0;

        // Jump while a response is in flight.
        tick();
        jump_en_i = 1'b1;
        jump_addr_i = 32'h100;
        tick();
        jump_en_i = 1'b0;
        @(negedge clk);
        check("jump_empty", 32'(inst_valid_o), 32'd0);
        check("jump_req", 32'(rom_req_o), 32'd1);
        check("jump_addr", rom_addr_o, 32'h100);
        expect_run(32'h100, 16);
        tick();
        inst_ready_i = 1'b1;

        // Halt for 5 cycles mid-stream.
        repeat (4) tick();
        jtag_halt_i = 1'b1;
        hg = gcount;
        hv = 0;
        repeat (5) begin
            @(negedge clk);
            if (inst_valid_o) hv++;
            tick();
        end
        jtag_halt_i = 1'b0;
        check("halt_grants", 32'(gcount - hg), 32'd0);
        check("halt_valids", 32'(hv), 32'd0);
        drain(60);
        inst_ready_i = 1'b0;

        // Fill from empty with decode stalled.
        tick();
        jump_en_i = 1'b1;
        jump_addr_i = 32'h400;
        tick();
        jump_en_i = 1'b0;
        gq.delete();
        repeat (10) @(negedge clk);
        check("full_grants", 32'(gq.size()), 32'd4);
        if (gq.size() == 4) begin
            check("full_first", gq[0], 32'h400);
            check("full_last", gq[3], 32'h40C);
        end
        check("full_req_off", 32'(rom_req_o), 32'd0);
        tick();
        expect_run(32'h400, 6);
        inst_ready_i = 1'b1;
        drain(40);
        inst_ready_i = 1'b0;

        // Debug reset outranks a simultaneous jump.
        tick();
        jtag_reset_i = 1'b1;
        jump_en_i = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        jtag_reset_i = 1'b0;
        jump_en_i = 1'b0;
        @(negedge clk);
        check("jreset_req", 32'(rom_req_o), 32'd1);
        check("jreset_addr", rom_addr_o, 32'h0);
        expect_run(32'h0, 3);
        tick();
        inst_ready_i = 1'b1;
        drain(30);
        inst_ready_i = 1'b0;

        // Response for 0x40 landing in an empty buffer.
        tick();
        jump_en_i = 1'b1;
        jump_addr_i = 32'h40;
        tick();
        jump_en_i = 1'b0;
        inst_ready_i = 1'b1;
        expect_run(32'h40, 3);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (rom_rvalid_i) begin
                seen = 1'b1;
                check("rv_valid", 32'(inst_valid_o), (LAT == 1) ? 32'd1 : 32'd0);
                check("rv_addr", inst_addr_o, (LAT == 1) ? 32'h40 : 32'h0);
            end
        end
        check("rv_seen", 32'(seen), 32'd1);
        drain(30);
        inst_ready_i = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
